// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  // Frame-parsing FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCheck,
    StDone,
    StErr
  } state_e;

  // Default start-of-frame marker.
  localparam logic [7:0] SyncByte = 8'hA5;

  // SYNC, LEN_LO and LEN_HI precede the payload.
  localparam int unsigned HdrBytes = 3;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader is the slave side: it sinks bytes and drives memory writes.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 6
) ();

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  im_we,
    input  im_addr,
    input  im_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output im_we,
    output im_addr,
    output im_wdata
  );

endinterface

// File: rtl/word_assembler.sv
// Packs payload bytes little-endian into 32-bit words and keeps the running
// XOR of every payload byte for the trailing checksum.
module word_assembler (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        last,
  output logic [31:0] word,
  output logic [7:0]  chk
);

  logic [1:0]  idx_q;
  logic [31:0] lanes_q;
  logic [31:0] lanes_d;
  logic [7:0]  xor_q;

  // Current byte dropped into its lane; word is complete when last is high.
  always_comb begin
    lanes_d = lanes_q;
    lanes_d[{idx_q, 3'b000} +: 8] = din;
  end

  // Byte index, lane register and checksum accumulator.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx_q   <= 2'd0;
      lanes_q <= 32'd0;
      xor_q   <= 8'd0;
    end else if (clr) begin
      idx_q   <= 2'd0;
      lanes_q <= 32'd0;
      xor_q   <= 8'd0;
    end else if (en) begin
      idx_q   <= idx_q + 2'd1;
      lanes_q <= lanes_d;
      xor_q   <= xor_q ^ din;
    end
  end

  assign last = (idx_q == 2'd3);
  assign word = lanes_d;
  assign chk  = xor_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses SYNC / LEN / payload / CHK frames from a byte stream,
// writes payload words into instruction memory and releases the core once
// the checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64,
  parameter logic [7:0]  SYNC   = SyncByte
) (
  input  logic          CLK,
  input  logic          RST_N,
  imem_loader_if.slave  bus,
  output logic          core_run,
  output logic          load_err,
  output logic [ADDR_W:0] words_loaded
);

  localparam logic [ADDR_W:0] WordOne = (ADDR_W + 1)'(1);

  state_e state_q, state_d;

  logic              rx_ready_q, rx_ready_d;
  logic              fire;
  logic [15:0]       len_q;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W:0]   words_inc;
  logic              im_we_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [31:0]       im_wdata_q;

  logic              acc_clr;
  logic              acc_en;
  logic              len_lo_we;
  logic              len_hi_we;
  logic              word_we;
  logic              asm_last;
  logic [31:0]       asm_word;
  logic [7:0]        asm_chk;

  assign fire      = bus.rx_valid & rx_ready_q;
  assign len_full  = {bus.rx_data, len_q[7:0]};
  assign words_inc = words_q + WordOne;

  word_assembler u_asm (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clr  (acc_clr),
    .en   (acc_en),
    .din  (bus.rx_data),
    .last (asm_last),
    .word (asm_word),
    .chk  (asm_chk)
  );

  // Next state and per-byte strobes; nothing moves without an accepted byte.
  always_comb begin
    state_d   = state_q;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    len_lo_we = 1'b0;
    len_hi_we = 1'b0;
    word_we   = 1'b0;
    if (fire) begin
      unique case (state_q)
        StIdle: begin
          if (bus.rx_data == SYNC) begin
            state_d = StLenLo;
            acc_clr = 1'b1;
          end
        end
        StLenLo: begin
          len_lo_we = 1'b1;
          state_d   = StLenHi;
        end
        StLenHi: begin
          len_hi_we = 1'b1;
          // Rejecting oversize frames here is what keeps the address from wrapping.
          if (len_full > 16'(DEPTH)) begin
            state_d = StErr;
          end else if (len_full == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          acc_en = 1'b1;
          if (asm_last) begin
            word_we = 1'b1;
            if (16'(words_inc) == len_q) begin
              state_d = StCheck;
            end
          end
        end
        StCheck: begin
          state_d = (bus.rx_data == asm_chk) ? StDone : StErr;
        end
        default: ;
      endcase
    end
  end

  // Ready is registered so it stays low during reset and drops with DONE/ERR.
  always_comb begin
    rx_ready_d = (state_d != StDone) && (state_d != StErr);
  end

  // FSM state and ready flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  // Length capture, word counter and the registered memory write port.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      len_q      <= 16'd0;
      words_q    <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= 32'd0;
    end else begin
      im_we_q <= word_we;
      if (len_lo_we) begin
        len_q[7:0] <= bus.rx_data;
      end
      if (len_hi_we) begin
        len_q[15:8] <= bus.rx_data;
      end
      if (word_we) begin
        im_addr_q  <= words_q[ADDR_W-1:0];
        im_wdata_q <= asm_word;
        words_q    <= words_inc;
      end
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;
  assign core_run     = (state_q == StDone);
  assign load_err     = (state_q == StErr);
  assign words_loaded = words_q;

endmodule
